wb_resp_arbiter: RTL and testbench

Parametrised N-input writeback response arbiter with a registered output slot. It picks one valid memory/execute response per cycle and holds it in a single-entry pipeline register until the writeback port accepts it. A response carries uop fields rob_idx, pdst, is_amo, uses_stq and dst_rtype, plus data and predicated. Priority is fixed or round-robin, selected at elaboration. Every input has backpressure, and the output supports flush. It sits between the LSU/execute response sources and the register-file writeback/ROB completion port.

---
 rtl/wb_resp_arbiter_pkg.sv | 25 ++
 rtl/wb_resp_arbiter_if.sv | 55 +++++
 rtl/wb_resp_arbiter_pick.sv | 33 +++
 rtl/wb_resp_arbiter.sv | 95 +++++++++
 tb/tb_wb_resp_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_resp_arbiter_pkg.sv
// Shared types and helpers for the writeback response arbiter.
// Uop fields are stored at maximum width and sliced to the configured width.
package wb_arb_pkg;

    localparam logic [1:0] RT_FIX = 2'd0;
    localparam logic [1:0] RT_FLT = 2'd1;
    localparam logic [1:0] RT_X   = 2'd2;
    localparam logic [1:0] RT_PAS = 2'd3;

    localparam int ROB_IDX_MAX = 16;
    localparam int PDST_MAX    = 16;

    typedef struct packed {
        logic [ROB_IDX_MAX-1:0] rob_idx;
        logic [PDST_MAX-1:0]    pdst;
        logic                   is_amo;
        logic                   uses_stq;
        logic [1:0]             dst_rtype;
    } wb_uop_t;

    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_resp_arbiter_if.sv
// Request/response bundle between response sources, the arbiter
// and the writeback port.
interface wb_resp_arbiter_if #(
    parameter int N_IN      = 2,
    parameter int DATA_W    = 64,
    parameter int ROB_IDX_W = 7,
    parameter int PDST_W    = 7
);
    localparam int SRC_W = wb_arb_pkg::src_w(N_IN);

    logic                      io_flush;
    logic [N_IN-1:0]           io_in_valid;
    logic [N_IN-1:0]           io_in_ready;
    logic [N_IN*ROB_IDX_W-1:0] io_in_bits_uop_rob_idx;
    logic [N_IN*PDST_W-1:0]    io_in_bits_uop_pdst;
    logic [N_IN-1:0]           io_in_bits_uop_is_amo;
    logic [N_IN-1:0]           io_in_bits_uop_uses_stq;
    logic [N_IN*2-1:0]         io_in_bits_uop_dst_rtype;
    logic [N_IN*DATA_W-1:0]    io_in_bits_data;
    logic [N_IN-1:0]           io_in_bits_predicated;

    logic                      io_out_valid;
    logic                      io_out_ready;
    logic [ROB_IDX_W-1:0]      io_out_bits_uop_rob_idx;
    logic [PDST_W-1:0]         io_out_bits_uop_pdst;
    logic                      io_out_bits_uop_is_amo;
    logic                      io_out_bits_uop_uses_stq;
    logic [1:0]                io_out_bits_uop_dst_rtype;
    logic [DATA_W-1:0]         io_out_bits_data;
    logic                      io_out_bits_predicated;
    logic [SRC_W-1:0]          io_out_src;

    modport master (
        output io_flush, io_in_valid, io_in_bits_uop_rob_idx,
        output io_in_bits_uop_pdst, io_in_bits_uop_is_amo,
        output io_in_bits_uop_uses_stq, io_in_bits_uop_dst_rtype,
        output io_in_bits_data, io_in_bits_predicated, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_uop_rob_idx,
        input  io_out_bits_uop_pdst, io_out_bits_uop_is_amo,
        input  io_out_bits_uop_uses_stq, io_out_bits_uop_dst_rtype,
        input  io_out_bits_data, io_out_bits_predicated, io_out_src
    );

    modport slave (
        input  io_flush, io_in_valid, io_in_bits_uop_rob_idx,
        input  io_in_bits_uop_pdst, io_in_bits_uop_is_amo,
        input  io_in_bits_uop_uses_stq, io_in_bits_uop_dst_rtype,
        input  io_in_bits_data, io_in_bits_predicated, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_uop_rob_idx,
        output io_out_bits_uop_pdst, io_out_bits_uop_is_amo,
        output io_out_bits_uop_uses_stq, io_out_bits_uop_dst_rtype,
        output io_out_bits_data, io_out_bits_predicated, io_out_src
    );

endinterface

// File: rtl/wb_resp_arbiter_pick.sv
// One-hot picker: first valid index at or after ptr, modulo N.
// With RR_MODE=0 the scan always starts at index 0.
module wb_prio_pick #(
    parameter int N       = 2,
    parameter int RR_MODE = 0,
    parameter int SRC_W   = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [SRC_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SRC_W-1:0] winner
);
    logic found;
    int   base;
    int   idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        base   = (RR_MODE != 0) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = SRC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wb_resp_arbiter.sv
// N-input writeback response arbiter with a single registered output slot.
// Inputs are only accepted when the slot is empty or draining this cycle.
module wb_resp_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int DATA_W    = 64,
    parameter int ROB_IDX_W = 7,
    parameter int PDST_W    = 7,
    parameter int RR_MODE   = 0
) (
    input logic            clock,
    input logic            reset,
    wb_resp_arbiter_if.slave io
);
    localparam int SRC_W = src_w(N_IN);

    logic              out_valid_q;
    wb_uop_t           uop_q;
    wb_uop_t           win_uop;
    logic [DATA_W-1:0] data_q;
    logic              pred_q;
    logic [SRC_W-1:0]  src_q;
    logic [SRC_W-1:0]  ptr_q;
    logic [SRC_W-1:0]  ptr_nxt;
    logic [SRC_W-1:0]  winner;
    logic [N_IN-1:0]   grant;
    logic              slot_free;
    logic              accept_en;
    logic              fire;
    int                w;

    wb_prio_pick #(
        .N       (N_IN),
        .RR_MODE (RR_MODE),
        .SRC_W   (SRC_W)
    ) u_pick (
        .valid  (io.io_in_valid),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    assign w         = int'(winner);
    assign slot_free = ~out_valid_q | io.io_out_ready;
    assign accept_en = slot_free & ~io.io_flush;
    assign fire      = accept_en & (|io.io_in_valid);

    // Reset gating keeps sources from handing off a response that would be lost.
    assign io.io_in_ready = {N_IN{accept_en & ~reset}} & grant;

    assign ptr_nxt = (RR_MODE == 0 || w == N_IN - 1) ? '0 : winner + 1'b1;

    always_comb begin
        win_uop = '0;
        win_uop.rob_idx =
            ROB_IDX_MAX'(io.io_in_bits_uop_rob_idx[w*ROB_IDX_W +: ROB_IDX_W]);
        win_uop.pdst =
            PDST_MAX'(io.io_in_bits_uop_pdst[w*PDST_W +: PDST_W]);
        win_uop.is_amo    = io.io_in_bits_uop_is_amo[winner];
        win_uop.uses_stq  = io.io_in_bits_uop_uses_stq[winner];
        win_uop.dst_rtype = io.io_in_bits_uop_dst_rtype[w*2 +: 2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            uop_q       <= '0;
            data_q      <= '0;
            pred_q      <= 1'b0;
            src_q       <= '0;
            ptr_q       <= '0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            uop_q       <= win_uop;
            data_q      <= io.io_in_bits_data[w*DATA_W +: DATA_W];
            pred_q      <= io.io_in_bits_predicated[winner];
            src_q       <= winner;
            ptr_q       <= ptr_nxt;
        end else if (io.io_out_ready | io.io_flush) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.io_out_valid              = out_valid_q;
    assign io.io_out_bits_uop_rob_idx   = uop_q.rob_idx[ROB_IDX_W-1:0];
    assign io.io_out_bits_uop_pdst      = uop_q.pdst[PDST_W-1:0];
    assign io.io_out_bits_uop_is_amo    = uop_q.is_amo;
    assign io.io_out_bits_uop_uses_stq  = uop_q.uses_stq;
    assign io.io_out_bits_uop_dst_rtype = uop_q.dst_rtype;
    assign io.io_out_bits_data          = data_q;
    assign io.io_out_bits_predicated    = pred_q;
    assign io.io_out_src                = src_q;

endmodule

// File: tb/tb_wb_resp_arbiter.sv
// Scoreboard bench: a 4-port round-robin arbiter and a 2-port
// fixed-priority arbiter driven from one shared stimulus set.
module tb_wb_resp_arbiter;
    import wb_arb_pkg::*;

    typedef struct {
        logic [6:0]  rob;
        logic [6:0]  pdst;
        logic        amo;
        logic        stq;
        logic [1:0]  rt;
        logic [63:0] data;
        logic        pred;
        logic [1:0]  src;
    } exp_t;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t q[2][$];
    int   ptr[2];

    wb_resp_arbiter_if #(.N_IN(4)) ia ();
    wb_resp_arbiter_if #(.N_IN(2)) ib ();

    wb_resp_arbiter #(.N_IN(4), .RR_MODE(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .io    (ia.slave)
    );

    wb_resp_arbiter #(.N_IN(2), .RR_MODE(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .io    (ib.slave)
    );

    assign ib.io_flush                 = ia.io_flush;
    assign ib.io_out_ready             = ia.io_out_ready;
    assign ib.io_in_valid              = ia.io_in_valid[1:0];
    assign ib.io_in_bits_uop_rob_idx   = ia.io_in_bits_uop_rob_idx[13:0];
    assign ib.io_in_bits_uop_pdst      = ia.io_in_bits_uop_pdst[13:0];
    assign ib.io_in_bits_uop_is_amo    = ia.io_in_bits_uop_is_amo[1:0];
    assign ib.io_in_bits_uop_uses_stq  = ia.io_in_bits_uop_uses_stq[1:0];
    assign ib.io_in_bits_uop_dst_rtype = ia.io_in_bits_uop_dst_rtype[3:0];
    assign ib.io_in_bits_data          = ia.io_in_bits_data[127:0];
    assign ib.io_in_bits_predicated    = ia.io_in_bits_predicated[1:0];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int i, input logic [6:0] r,
                            input logic [6:0] p, input logic amo,
                            input logic stq, input logic [1:0] rt,
                            input logic [63:0] d, input logic pr);
        ia.io_in_bits_uop_rob_idx[i*7 +: 7]   = r;
        ia.io_in_bits_uop_pdst[i*7 +: 7]      = p;
        ia.io_in_bits_uop_is_amo[i]           = amo;
        ia.io_in_bits_uop_uses_stq[i]         = stq;
        ia.io_in_bits_uop_dst_rtype[i*2 +: 2] = rt;
        ia.io_in_bits_data[i*64 +: 64]        = d;
        ia.io_in_bits_predicated[i]           = pr;
    endtask

    function automatic int pick(input logic [3:0] v, input int n,
                                input bit rr, input int p);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = rr ? (p + k) % n : k;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t mk(input int i);
        exp_t e;
        e.rob  = ia.io_in_bits_uop_rob_idx[i*7 +: 7];
        e.pdst = ia.io_in_bits_uop_pdst[i*7 +: 7];
        e.amo  = ia.io_in_bits_uop_is_amo[i];
        e.stq  = ia.io_in_bits_uop_uses_stq[i];
        e.rt   = ia.io_in_bits_uop_dst_rtype[i*2 +: 2];
        e.data = ia.io_in_bits_data[i*64 +: 64];
        e.pred = ia.io_in_bits_predicated[i];
        e.src  = 2'(i);
        return e;
    endfunction

    function automatic exp_t got_of(input int d);
        exp_t g;
        if (d == 0) begin
            g.rob  = ia.io_out_bits_uop_rob_idx;
            g.pdst = ia.io_out_bits_uop_pdst;
            g.amo  = ia.io_out_bits_uop_is_amo;
            g.stq  = ia.io_out_bits_uop_uses_stq;
            g.rt   = ia.io_out_bits_uop_dst_rtype;
            g.data = ia.io_out_bits_data;
            g.pred = ia.io_out_bits_predicated;
            g.src  = ia.io_out_src;
        end else begin
            g.rob  = ib.io_out_bits_uop_rob_idx;
            g.pdst = ib.io_out_bits_uop_pdst;
            g.amo  = ib.io_out_bits_uop_is_amo;
            g.stq  = ib.io_out_bits_uop_uses_stq;
            g.rt   = ib.io_out_bits_uop_dst_rtype;
            g.data = ib.io_out_bits_data;
            g.pred = ib.io_out_bits_predicated;
            g.src  = {1'b0, ib.io_out_src};
        end
        return g;
    endfunction

    task automatic eval_in(input int d);
        int         n;
        bit         rr;
        logic [3:0] v;
        logic [3:0] rdy_got;
        logic [3:0] rdy_exp;
        bit         mv;
        bit         acc;
        int         w;
        n       = (d == 0) ? 4 : 2;
        rr      = (d == 0);
        v       = (d == 0) ? ia.io_in_valid : {2'b00, ia.io_in_valid[1:0]};
        rdy_got = (d == 0) ? ia.io_in_ready : {2'b00, ib.io_in_ready};
        rdy_exp = '0;
        mv      = (q[d].size() != 0);
        acc     = (!mv || ia.io_out_ready) && !ia.io_flush && !reset;
        w       = pick(v, n, rr, ptr[d]);
        if (acc && w >= 0) rdy_exp[w] = 1'b1;
        chk($sformatf("ready%0d", d), 64'(rdy_got), 64'(rdy_exp));
        if (reset) begin
            q[d].delete();
            ptr[d] = 0;
        end else begin
            if (mv && (ia.io_out_ready || ia.io_flush))
                void'(q[d].pop_front());
            if (acc && w >= 0) begin
                q[d].push_back(mk(w));
                if (rr) ptr[d] = (w == n - 1) ? 0 : w + 1;
            end
        end
    endtask

    task automatic chk_out(input int d, input bit was_rst);
        exp_t g;
        exp_t e;
        logic vld;
        g   = got_of(d);
        vld = (d == 0) ? ia.io_out_valid : ib.io_out_valid;
        if (q[d].size() != 0) begin
            e = q[d][0];
            chk($sformatf("valid%0d", d), 64'(vld), 64'd1);
        end else begin
            e = '{default: '0};
            chk($sformatf("valid%0d", d), 64'(vld), 64'd0);
        end
        if (q[d].size() != 0 || was_rst) begin
            chk($sformatf("rob%0d", d), 64'(g.rob), 64'(e.rob));
            chk($sformatf("pdst%0d", d), 64'(g.pdst), 64'(e.pdst));
            chk($sformatf("amo%0d", d), 64'(g.amo), 64'(e.amo));
            chk($sformatf("stq%0d", d), 64'(g.stq), 64'(e.stq));
            chk($sformatf("rtype%0d", d), 64'(g.rt), 64'(e.rt));
            chk($sformatf("data%0d", d), g.data, e.data);
            chk($sformatf("pred%0d", d), 64'(g.pred), 64'(e.pred));
            chk($sformatf("src%0d", d), 64'(g.src), 64'(e.src));
        end
    endtask

    task automatic cyc();
        bit r;
        #1;
        r = reset;
        eval_in(0);
        eval_in(1);
        @(posedge clock);
        #1;
        chk_out(0, r);
        chk_out(1, r);
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ptr[0] = 0;
        ptr[1] = 0;
        reset = 1'b1;
        ia.io_flush = 1'b0;
        ia.io_out_ready = 1'b0;
        ia.io_in_valid = '0;
        for (int i = 0; i < 4; i++)
            set_port(i, 7'(16 + i), 7'(32 + i), i[0], i[1], RT_FIX,
                     64'(100 + i), 1'b0);
        @(negedge clock);
        cyc();
        cyc();
        reset = 1'b0;

        // fixed priority: port 0 beats port 1
        set_port(0, 7'd5, 7'd1, 1'b0, 1'b1, RT_FLT, 64'h11, 1'b0);
        set_port(1, 7'd9, 7'd2, 1'b1, 1'b0, RT_X, 64'h22, 1'b0);
        ia.io_in_valid = 4'b0011;
        ia.io_out_ready = 1'b1;
        #1;
        chk("fix_ready", 64'(ib.io_in_ready), 64'b01);
        cyc();
        chk("fix_rob", 64'(ib.io_out_bits_uop_rob_idx), 64'd5);
        chk("fix_src", 64'(ib.io_out_src), 64'd0);

        // round-robin rotation from a fresh pointer
        reset = 1'b1;
        ia.io_in_valid = '0;
        cyc();
        reset = 1'b0;
        ia.io_in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr_seq", 64'(ia.io_out_src), 64'(k % 4));
        end

        // backpressure then drain-and-replace
        ia.io_in_valid = 4'b0001;
        cyc();
        ia.io_out_ready = 1'b0;
        ia.io_in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 64'(ia.io_in_ready), 64'd0);
            cyc();
        end
        ia.io_out_ready = 1'b1;
        #1;
        chk("bp_accept", 64'(ia.io_in_ready), 64'b0100);
        cyc();
        chk("bp_valid", 64'(ia.io_out_valid), 64'd1);
        chk("bp_src", 64'(ia.io_out_src), 64'd2);
        ia.io_in_valid = '0;
        cyc();

        // flush drops the held entry and leaves the pointer alone
        set_port(0, 7'h12, 7'd3, 1'b0, 1'b0, RT_PAS, 64'h33, 1'b0);
        ia.io_in_valid = 4'b0001;
        cyc();
        ia.io_out_ready = 1'b0;
        ia.io_flush = 1'b1;
        ia.io_in_valid = 4'b0010;
        #1;
        chk("fl_ready", 64'(ia.io_in_ready), 64'd0);
        cyc();
        chk("fl_valid", 64'(ia.io_out_valid), 64'd0);
        ia.io_flush = 1'b0;
        ia.io_out_ready = 1'b1;
        ia.io_in_valid = 4'b1111;
        cyc();
        chk("fl_ptr", 64'(ia.io_out_src), 64'd1);

        // predicated and data follow the winning port
        set_port(1, 7'd7, 7'd4, 1'b0, 1'b0, RT_FIX,
                 64'hDEAD_BEEF_0000_0001, 1'b1);
        ia.io_in_valid = 4'b0010;
        cyc();
        chk("pr1_pred", 64'(ia.io_out_bits_predicated), 64'd1);
        chk("pr1_data", ia.io_out_bits_data, 64'hDEAD_BEEF_0000_0001);
        ia.io_in_valid = 4'b0001;
        cyc();
        chk("pr0_pred", 64'(ia.io_out_bits_predicated), 64'd0);

        // reset while holding an entry
        cyc();
        ia.io_out_ready = 1'b0;
        ia.io_in_valid = '0;
        cyc();
        reset = 1'b1;
        ia.io_in_valid = 4'b1111;
        cyc();
        reset = 1'b0;
        chk("rst_valid", 64'(ia.io_out_valid), 64'd0);
        chk("rst_src", 64'(ia.io_out_src), 64'd0);
        ia.io_out_ready = 1'b1;
        cyc();
        chk("rst_ptr", 64'(ia.io_out_src), 64'd0);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            ia.io_in_valid  = 4'($urandom);
            ia.io_out_ready = ($urandom_range(0, 3) != 0);
            ia.io_flush     = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 4; i++)
                set_port(i, 7'($urandom), 7'($urandom), 1'($urandom),
                         1'($urandom), 2'($urandom),
                         {$urandom, $urandom}, 1'($urandom));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
